splitter_1_to_2: RTL
====================

SPLITTER_1_TO_2 -- requirements
Module: splitter_1_to_2

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of every data port.
REQ-002 Parameter FLUSH_TIMEOUT, default 16, legal range 2..255: idle cycles before a lone beat is flushed (REQ-017).
REQ-003 Single clock and asynchronous active-high reset; every register and port below is on this clock domain.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 in_data  input  DATA_WIDTH  input beat.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_last  input  1  beat closes its group; qualified by in_valid.
REQ-009 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-010 out1_data / out2_data  output  DATA_WIDTH  first and second beat of a pair, registered.
REQ-011 out1_valid / out2_valid  output  1  lane valid, registered; out2_valid=1 implies out1_valid=1.
REQ-012 out_ready  input  1  shared; a pair or single transfers when out1_valid && out_ready.

Function
REQ-013 Holding slot: slot_data, slot_valid, slot_last; output_free = !out1_valid || out_ready; in_ready = !slot_valid || output_free (combinational).
REQ-014 Slot empty, beat accepted: if in_last && output_free, emit single (out1=beat, out2_valid=0) next cycle; else load slot (slot_last=in_last).
REQ-015 Slot valid, !slot_last, beat accepted: emit pair (out1=slot_data, out2=in_data, both valid) next cycle; slot cleared.
REQ-016 Slot valid, slot_last, output_free: emit single from slot; a beat accepted in the same cycle loads the slot per REQ-014 load rule (never emitted directly).
REQ-017 Lone-beat timer (REQ-026 only): counts cycles with slot_valid && !slot_last and no accepted beat; cleared on slot load; at FLUSH_TIMEOUT-1 with output_free, emit single from slot; if output not free, timer saturates and flush occurs on first free cycle.
REQ-018 Output registers hold data/valid unchanged while out1_valid && !out_ready; unused lane data is don't-care but SHALL be driven 0 when its valid is 0.
REQ-019 Ordering preserved: out1 always carries the earlier beat; no beat dropped or duplicated.
REQ-020 Latency: 1 cycle from completing input transfer (or flush) to output valid; sustained throughput one input beat per cycle with out_ready held 1.
REQ-021 Simultaneous output transfer and new emit: output registers reload in the same cycle, no bubble.

Reset
REQ-022 Asserting reset clears out1/out2 data and valid, slot_data/valid/last and timer to 0 immediately, independent of clock.
REQ-023 in_ready SHALL be 1 during and after reset (slot empty).
REQ-024 Reset mid-pair discards the slot and any output in flight; first post-reset beat is treated as a pair head.

Configuration
REQ-025 Macro SPLITTER_1_TO_2_FLUSH_TIMEOUT_EN selects the lone-beat timer.
REQ-026 Defined: REQ-017 active, timer width ceil(log2(FLUSH_TIMEOUT)). Undefined: no timer logic, a lone non-last beat waits in the slot indefinitely until its partner or reset; FLUSH_TIMEOUT ignored.

Structure
REQ-027 Package splitter_pkg holds the emit-kind constants (EMIT_NONE, EMIT_SINGLE_IN, EMIT_PAIR, EMIT_SINGLE_SLOT) shared with arbiter-side test code.
REQ-028 Timer implemented as sub-module flush_timer (inputs clock, reset, clear, count_en; output expired); instantiated only under the macro.

Verification
REQ-029 Beats A,B (in_last=0,1), out_ready=1 -> one cycle after B: out1=A, out2=B, both valid; in_ready stays 1.
REQ-030 Single beat C with in_last=1, empty slot, out_ready=1 -> next cycle out1=C, out1_valid=1, out2_valid=0, out2_data=0.
REQ-031 Stream 0x01..0x08 every cycle, last on 0x02/0x04/0x06/0x08, out_ready=1 -> pairs (1,2),(3,4),(5,6),(7,8) on consecutive odd cycles, no stall.
REQ-032 out_ready=0 with pair (1,2) held, send 3 (last=0) then 4 -> 3 enters slot, in_ready drops to 0; pair held stable; out_ready=1 -> (3,4) follows next cycle.
REQ-033 Macro defined, FLUSH_TIMEOUT=4, beat 0x55 (last=0) then idle -> single 0x55 emitted 4 cycles after acceptance; macro undefined -> no output after 50 cycles.
REQ-034 Reset asserted asynchronously while slot holds a beat and out1_valid=1 -> all valids 0 before next clock edge, in_ready=1.

Source files
------------

// File: rtl/splitter_pkg.sv
// ---------------------------------------------------------------------------
// splitter_pkg
//   Shared definitions for the 1-to-2 beat splitter.
//   - emit_kind_e : what the splitter loads into its output registers in a
//                   given cycle. Arbiter-side test code uses the same values.
//   - timer_width : width of the lone-beat flush counter for a given timeout.
// ---------------------------------------------------------------------------
package splitter_pkg;

  typedef enum logic [1:0] {
    EMIT_NONE        = 2'd0,  // output registers hold or drain
    EMIT_SINGLE_IN   = 2'd1,  // incoming last beat goes straight to out1
    EMIT_PAIR        = 2'd2,  // slot beat to out1, incoming beat to out2
    EMIT_SINGLE_SLOT = 2'd3   // slot beat alone to out1
  } emit_kind_e;

  // ceil(log2(timeout)), never below one bit so the counter always exists.
  function automatic int unsigned timer_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : splitter_pkg

// File: rtl/flush_timer.sv
// ---------------------------------------------------------------------------
// flush_timer
//   Saturating idle counter for a lone (unpaired, non-last) beat in the
//   splitter's holding slot. `expired` is high once the counter has reached
//   FLUSH_TIMEOUT-1 and stays high until `clear`.
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   clear    in   return the count to zero (wins over count_en)
//   count_en in   advance the count by one (saturates at FLUSH_TIMEOUT-1)
//   expired  out  count == FLUSH_TIMEOUT-1
// ---------------------------------------------------------------------------
module flush_timer
  import splitter_pkg::*;
#(
  parameter int unsigned FLUSH_TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = timer_width(FLUSH_TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(FLUSH_TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && (count_q != LIMIT)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule : flush_timer

// File: rtl/splitter_1_to_2.sv
// ---------------------------------------------------------------------------
// splitter_1_to_2
//   Packs a stream of beats into pairs. The first beat of a pair waits in a
//   one-entry holding slot; when its partner arrives both are presented
//   together on out1/out2. A beat marked in_last that starts a group is sent
//   alone on out1 (out2_valid = 0). out1 always carries the earlier beat.
//
//   Optional feature (macro SPLITTER_1_TO_2_FLUSH_TIMEOUT_EN): a lone non-last
//   beat that sits in the slot for FLUSH_TIMEOUT-1 idle cycles is flushed out
//   as a single. Without the macro the beat waits for its partner or reset.
//
// Parameters
//   DATA_WIDTH     width of every data port
//   FLUSH_TIMEOUT  idle cycles before a lone beat is flushed (2..255)
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   in_data     in   input beat
//   in_valid    in   in_data valid
//   in_last     in   beat closes its group (qualified by in_valid)
//   in_ready    out  beat accepted when in_valid && in_ready
//   out1_data   out  first beat of the pair (registered, 0 when invalid)
//   out1_valid  out  out1 lane valid (registered)
//   out2_data   out  second beat of the pair (registered, 0 when invalid)
//   out2_valid  out  out2 lane valid (registered, implies out1_valid)
//   out_ready   in   shared: output transfers when out1_valid && out_ready
// ---------------------------------------------------------------------------
module splitter_1_to_2
  import splitter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned FLUSH_TIMEOUT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic                  out1_valid,
  output logic [DATA_WIDTH-1:0] out2_data,
  output logic                  out2_valid,
  input  logic                  out_ready
);

  // Out-of-range timeouts are rejected at elaboration.
  if ((FLUSH_TIMEOUT < 2) || (FLUSH_TIMEOUT > 255)) begin : g_bad_flush_timeout
    $error("splitter_1_to_2: FLUSH_TIMEOUT must lie in 2..255");
  end

  // Holding slot
  logic [DATA_WIDTH-1:0] slot_data_q;
  logic [DATA_WIDTH-1:0] slot_data_d;
  logic                  slot_valid_q;
  logic                  slot_valid_d;
  logic                  slot_last_q;
  logic                  slot_last_d;

  // Output registers
  logic [DATA_WIDTH-1:0] out1_data_q;
  logic [DATA_WIDTH-1:0] out1_data_d;
  logic [DATA_WIDTH-1:0] out2_data_q;
  logic [DATA_WIDTH-1:0] out2_data_d;
  logic                  out1_valid_q;
  logic                  out1_valid_d;
  logic                  out2_valid_q;
  logic                  out2_valid_d;

  logic       output_free;
  logic       in_fire;
  logic       flush_expired;
  emit_kind_e emit_kind;

  // The output registers can take new content when empty or when their
  // current content leaves this cycle.
  assign output_free = !out1_valid_q || out_ready;
  // A beat can always be taken into an empty slot; a full slot only frees
  // up when its content can move to the output this cycle.
  assign in_ready    = !slot_valid_q || output_free;
  assign in_fire     = in_valid && in_ready;

  // -------------------------------------------------------------------------
  // Lone-beat flush timer
  // -------------------------------------------------------------------------
`ifdef SPLITTER_1_TO_2_FLUSH_TIMEOUT_EN
  logic timer_count_en;
  logic timer_clear;

  // Count only while a pair head waits with no partner arriving. Every other
  // cycle clears, so a freshly loaded slot always starts from zero.
  assign timer_count_en = slot_valid_q && !slot_last_q && !in_fire;
  assign timer_clear    = !timer_count_en;

  flush_timer #(
    .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
  ) u_flush_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (timer_clear),
    .count_en (timer_count_en),
    .expired  (flush_expired)
  );
`else
  assign flush_expired = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Slot control and emit decision
  // -------------------------------------------------------------------------
  always_comb begin
    emit_kind    = EMIT_NONE;
    slot_data_d  = slot_data_q;
    slot_valid_d = slot_valid_q;
    slot_last_d  = slot_last_q;

    if (!slot_valid_q) begin
      // Empty slot: a last beat bypasses the slot only if the output can
      // take it now; anything else becomes the new slot content.
      if (in_fire) begin
        if (in_last && output_free) begin
          emit_kind = EMIT_SINGLE_IN;
        end else begin
          slot_data_d  = in_data;
          slot_valid_d = 1'b1;
          slot_last_d  = in_last;
        end
      end
    end else if (!slot_last_q) begin
      // Pair head waiting. in_fire implies output_free here. A partner
      // beat takes precedence over a flush in the same cycle.
      if (in_fire) begin
        emit_kind    = EMIT_PAIR;
        slot_data_d  = '0;
        slot_valid_d = 1'b0;
        slot_last_d  = 1'b0;
      end else if (flush_expired && output_free) begin
        emit_kind    = EMIT_SINGLE_SLOT;
        slot_data_d  = '0;
        slot_valid_d = 1'b0;
        slot_last_d  = 1'b0;
      end
    end else begin
      // Slot holds a complete single. A beat arriving in the same cycle
      // refills the slot rather than going out directly, which keeps the
      // output ordering trivially correct.
      if (output_free) begin
        emit_kind    = EMIT_SINGLE_SLOT;
        slot_data_d  = '0;
        slot_valid_d = 1'b0;
        slot_last_d  = 1'b0;
        if (in_fire) begin
          slot_data_d  = in_data;
          slot_valid_d = 1'b1;
          slot_last_d  = in_last;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register load
  // -------------------------------------------------------------------------
  always_comb begin
    out1_data_d  = out1_data_q;
    out2_data_d  = out2_data_q;
    out1_valid_d = out1_valid_q;
    out2_valid_d = out2_valid_q;

    unique case (emit_kind)
      EMIT_SINGLE_IN: begin
        out1_data_d  = in_data;
        out1_valid_d = 1'b1;
        out2_data_d  = '0;
        out2_valid_d = 1'b0;
      end
      EMIT_PAIR: begin
        out1_data_d  = slot_data_q;
        out1_valid_d = 1'b1;
        out2_data_d  = in_data;
        out2_valid_d = 1'b1;
      end
      EMIT_SINGLE_SLOT: begin
        out1_data_d  = slot_data_q;
        out1_valid_d = 1'b1;
        out2_data_d  = '0;
        out2_valid_d = 1'b0;
      end
      default: begin
        // Nothing new: drain to zero once the current content has left,
        // otherwise hold it stable for the consumer.
        if (output_free) begin
          out1_data_d  = '0;
          out1_valid_d = 1'b0;
          out2_data_d  = '0;
          out2_valid_d = 1'b0;
        end
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_data_q  <= '0;
      slot_valid_q <= 1'b0;
      slot_last_q  <= 1'b0;
      out1_data_q  <= '0;
      out2_data_q  <= '0;
      out1_valid_q <= 1'b0;
      out2_valid_q <= 1'b0;
    end else begin
      slot_data_q  <= slot_data_d;
      slot_valid_q <= slot_valid_d;
      slot_last_q  <= slot_last_d;
      out1_data_q  <= out1_data_d;
      out2_data_q  <= out2_data_d;
      out1_valid_q <= out1_valid_d;
      out2_valid_q <= out2_valid_d;
    end
  end

  assign out1_data  = out1_data_q;
  assign out2_data  = out2_data_q;
  assign out1_valid = out1_valid_q;
  assign out2_valid = out2_valid_q;

endmodule : splitter_1_to_2
